// File: rtl/wb_pkg.sv
// Shared constants and types for the RV32 write-back stage.
package wb_pkg;

    localparam int TRACE_W_DEF = 309;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        WB_IDLE,
        WB_WAIT
    } wb_state_e;

endpackage

// File: rtl/wb_load_align.sv
// Picks the addressed byte/halfword out of a word-aligned load and extends it.
module wb_load_align
    import wb_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] rdata,
    output logic [31:0] data
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{off, 3'b000} +: 8];
        // Halfword lane comes from addr[1] alone; a misaligned addr[0] is dropped.
        half_sel = rdata[{off[1], 4'b0000} +: 16];
        case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data = {24'd0, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  data = {16'd0, half_sel};
            default: data = rdata;
        endcase
    end
endmodule

// File: rtl/wb_pipe.sv
// Write-back stage: retires ALU results directly, holds loads until data
// arrives (or the watchdog expires), and drives the register-file write port.
module wb_pipe
    import wb_pkg::*;
#(
    parameter int TRACE_W = TRACE_W_DEF,
    parameter int TMO_CYC = 255
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_vld,
    output logic               o_rdy,
    input  logic               i_mem_reg,
    input  logic [2:0]         i_funct3,
    input  logic [31:0]        i_res,
    input  logic [31:0]        i_dmem_addr,
    input  logic [4:0]         i_rd_waddr,
    input  logic               i_rd_wen,
    input  logic [TRACE_W-1:0] i_trace,
    input  logic               i_dmem_rvld,
    input  logic [31:0]        i_dmem_rdata,
    output logic [31:0]        o_rd_wdata,
    output logic [4:0]         o_rd_waddr,
    output logic               o_rd_wen,
    output logic               o_vld,
    output logic [TRACE_W-1:0] o_trace,
    output logic               o_err
);
    wb_state_e          state;
    logic [2:0]         f3_q;
    logic [1:0]         off_q;
    logic [4:0]         waddr_q;
    logic               wen_q;
    logic [TRACE_W-1:0] trace_q;
    logic [31:0]        load_data;
    logic               accept;
    logic               tmo_hit;
    logic               unused_addr;

    assign unused_addr = ^i_dmem_addr[31:2];
    assign o_rdy  = (state == WB_IDLE);
    assign accept = i_vld & o_rdy;

    // A same-cycle load response in IDLE must align with the live inputs.
    wb_load_align u_align (
        .funct3 (o_rdy ? i_funct3 : f3_q),
        .off    (o_rdy ? i_dmem_addr[1:0] : off_q),
        .rdata  (i_dmem_rdata),
        .data   (load_data)
    );

    generate
        if (TMO_CYC > 0) begin : g_wdog
            localparam int CW = $clog2(TMO_CYC + 1);
            logic [CW-1:0] cnt;
            always_ff @(posedge i_clk) begin
                if (i_rst || state == WB_IDLE)
                    cnt <= '0;
                else if (!i_dmem_rvld)
                    cnt <= cnt + CW'(1);
            end
            assign tmo_hit = (state == WB_WAIT) && !i_dmem_rvld && (cnt == CW'(TMO_CYC - 1));
        end else begin : g_no_wdog
            assign tmo_hit = 1'b0;
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (accept) begin
            f3_q    <= i_funct3;
            off_q   <= i_dmem_addr[1:0];
            waddr_q <= i_rd_waddr;
            wen_q   <= i_rd_wen;
            trace_q <= i_trace;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= WB_IDLE;
            o_vld      <= 1'b0;
            o_rd_wen   <= 1'b0;
            o_rd_wdata <= '0;
            o_rd_waddr <= '0;
            o_trace    <= '0;
            o_err      <= 1'b0;
        end else begin
            o_vld    <= 1'b0;
            o_rd_wen <= 1'b0;
            case (state)
                WB_IDLE: begin
                    if (accept) begin
                        if (!i_mem_reg || i_dmem_rvld) begin
                            o_vld      <= 1'b1;
                            o_rd_wen   <= i_rd_wen && (i_rd_waddr != 5'd0);
                            o_rd_waddr <= i_rd_waddr;
                            o_rd_wdata <= i_mem_reg ? load_data : i_res;
                            o_trace    <= i_trace;
                        end else begin
                            state <= WB_WAIT;
                        end
                    end
                end
                WB_WAIT: begin
                    if (i_dmem_rvld) begin
                        o_vld      <= 1'b1;
                        o_rd_wen   <= wen_q && (waddr_q != 5'd0);
                        o_rd_waddr <= waddr_q;
                        o_rd_wdata <= load_data;
                        o_trace    <= trace_q;
                        state      <= WB_IDLE;
                    end else if (tmo_hit) begin
                        // Retire without a register write so the pipeline keeps moving.
                        o_vld      <= 1'b1;
                        o_rd_waddr <= waddr_q;
                        o_trace    <= trace_q;
                        o_err      <= 1'b1;
                        state      <= WB_IDLE;
                    end
                end
                default: state <= WB_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_pipe.sv
// Bench for wb_pipe: alignment table, directed latency/timeout/reset sequences,
// and randomized instruction streams against a behavioural model.
module tb_wb_pipe;
    localparam int TW  = 309;
    localparam int TMO = 8;

    logic          i_clk = 1'b0;
    logic          i_rst, i_vld, o_rdy, i_mem_reg, i_rd_wen, i_dmem_rvld;
    logic [2:0]    i_funct3;
    logic [31:0]   i_res, i_dmem_addr, i_dmem_rdata, o_rd_wdata;
    logic [4:0]    i_rd_waddr, o_rd_waddr;
    logic          o_rd_wen, o_vld, o_err;
    logic [TW-1:0] i_trace, o_trace;

    int total = 0;
    int bad   = 0;
    logic err_m = 1'b0;

    wb_pipe #(.TRACE_W(TW), .TMO_CYC(TMO)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_vld(i_vld), .o_rdy(o_rdy),
        .i_mem_reg(i_mem_reg), .i_funct3(i_funct3), .i_res(i_res),
        .i_dmem_addr(i_dmem_addr), .i_rd_waddr(i_rd_waddr), .i_rd_wen(i_rd_wen),
        .i_trace(i_trace), .i_dmem_rvld(i_dmem_rvld), .i_dmem_rdata(i_dmem_rdata),
        .o_rd_wdata(o_rd_wdata), .o_rd_waddr(o_rd_waddr), .o_rd_wen(o_rd_wen),
        .o_vld(o_vld), .o_trace(o_trace), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [31:0] exp;
    } align_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_trace(input string name, input logic [TW-1:0] exp);
        total++;
        if (o_trace !== exp) begin
            bad++;
            $display("FAIL %s: got low %h expected low %h", name, o_trace[31:0], exp[31:0]);
        end
    endtask

    function automatic logic [TW-1:0] mk_trace(input logic [31:0] tag);
        logic [TW-1:0] t;
        t = '0;
        t[31:0] = tag;
        t[TW-1 -: 32] = ~tag;
        return t;
    endfunction

    // Reference load extraction, done with shifts and integer range checks.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * off[1])) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
            3'b100:  return b;
            3'b001:  return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_vld = 0; i_mem_reg = 0; i_funct3 = 0; i_res = 0; i_dmem_addr = 0;
        i_rd_waddr = 0; i_rd_wen = 0; i_trace = '0; i_dmem_rvld = 0; i_dmem_rdata = 0;
    endtask

    // Issues one instruction and follows it to retirement. delay = WAIT cycle in
    // which rvld is raised (0 = same cycle as accept); beyond TMO it times out.
    task automatic run_instr(input logic is_load, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] res, input logic [4:0] rd, input logic wen,
                             input logic [31:0] rdata, input int delay, input logic [31:0] tag);
        logic [31:0] exp_d;
        logic        tmo;
        tmo   = 1'b0;
        exp_d = is_load ? ref_load(f3, addr[1:0], rdata) : res;
        chk("rdy_before_accept", {31'd0, o_rdy}, 32'd1);
        i_vld = 1; i_mem_reg = is_load; i_funct3 = f3; i_dmem_addr = addr; i_res = res;
        i_rd_waddr = rd; i_rd_wen = wen; i_trace = mk_trace(tag);
        i_dmem_rvld = is_load && (delay == 0);
        i_dmem_rdata = (delay == 0) ? rdata : $urandom;
        tick();
        // Scramble the request fields so a missed capture shows up.
        i_vld = 0; i_funct3 = 3'($urandom); i_dmem_addr = $urandom; i_res = $urandom;
        i_rd_waddr = 5'($urandom); i_rd_wen = 1'($urandom); i_trace = mk_trace($urandom);
        i_dmem_rvld = 0;
        if (is_load && delay != 0) begin
            for (int k = 1; k <= TMO; k++) begin
                chk("wait_rdy", {31'd0, o_rdy}, 32'd0);
                chk("wait_vld", {31'd0, o_vld}, 32'd0);
                if (k == delay) begin
                    i_dmem_rvld = 1; i_dmem_rdata = rdata;
                    tick();
                    i_dmem_rvld = 0; i_dmem_rdata = $urandom;
                    break;
                end
                tick();
                if (k == TMO) tmo = 1'b1;
            end
        end
        if (tmo) err_m = 1'b1;
        chk("ret_vld", {31'd0, o_vld}, 32'd1);
        chk("ret_wen", {31'd0, o_rd_wen}, {31'd0, !tmo && wen && rd != 5'd0});
        chk("ret_waddr", {27'd0, o_rd_waddr}, {27'd0, rd});
        if (!tmo) chk("ret_wdata", o_rd_wdata, exp_d);
        chk_trace("ret_trace", mk_trace(tag));
        chk("ret_err", {31'd0, o_err}, {31'd0, err_m});
    endtask

    align_vec_t av[$];

    initial begin
        idle_inputs();
        i_rst = 1;
        tick(); tick();
        i_rst = 0;
        tick();
        chk("rst_vld", {31'd0, o_vld}, 32'd0);
        chk("rst_wen", {31'd0, o_rd_wen}, 32'd0);
        chk("rst_wdata", o_rd_wdata, 32'd0);
        chk("rst_waddr", {27'd0, o_rd_waddr}, 32'd0);
        chk_trace("rst_trace", '0);
        chk("rst_err", {31'd0, o_err}, 32'd0);
        chk("rst_rdy", {31'd0, o_rdy}, 32'd1);

        // Back-to-back ALU ops retire every cycle; rd=0 suppresses the write.
        run_instr(0, 3'd0, 0, 32'h11, 5'd5, 1, 0, 0, 32'hA1);
        run_instr(0, 3'd0, 0, 32'h22, 5'd6, 1, 0, 0, 32'hA2);
        run_instr(0, 3'd0, 0, 32'h33, 5'd0, 1, 0, 0, 32'hA3);
        tick();
        chk("pulse_end", {31'd0, o_vld}, 32'd0);

        av.push_back('{3'b000, 32'h1000, 32'h80FF7F01, 32'h00000001});
        av.push_back('{3'b000, 32'h1001, 32'h80FF7F01, 32'h0000007F});
        av.push_back('{3'b000, 32'h1002, 32'h80FF7F01, 32'hFFFFFFFF});
        av.push_back('{3'b000, 32'h1003, 32'h80FF7F01, 32'hFFFFFF80});
        av.push_back('{3'b100, 32'h1003, 32'h80FF7F01, 32'h00000080});
        av.push_back('{3'b001, 32'h2002, 32'h80017FFE, 32'hFFFF8001});
        av.push_back('{3'b101, 32'h2002, 32'h80017FFE, 32'h00008001});
        av.push_back('{3'b001, 32'h2000, 32'h80017FFE, 32'h00007FFE});
        av.push_back('{3'b101, 32'h2003, 32'h80017FFE, 32'h00008001});
        av.push_back('{3'b010, 32'h2001, 32'h80017FFE, 32'h80017FFE});
        av.push_back('{3'b111, 32'h2003, 32'hDEADBEEF, 32'hDEADBEEF});
        foreach (av[i]) begin
            i_vld = 1; i_mem_reg = 1; i_funct3 = av[i].f3; i_dmem_addr = av[i].addr;
            i_res = 32'h5555_5555; i_rd_waddr = 5'd9; i_rd_wen = 1;
            i_dmem_rvld = 1; i_dmem_rdata = av[i].rdata; i_trace = mk_trace(i);
            tick();
            chk("align_vld", {31'd0, o_vld}, 32'd1);
            chk($sformatf("align_%0d", i), o_rd_wdata, av[i].exp);
        end
        idle_inputs();
        tick();

        // Load response four WAIT cycles after accept.
        run_instr(1, 3'b010, 32'h40, 0, 5'd7, 1, 32'hCAFE_F00D, 4, 32'hB1);
        // Stray response while idle.
        i_dmem_rvld = 1; i_dmem_rdata = 32'h1234;
        tick();
        i_dmem_rvld = 0;
        chk("stray_vld", {31'd0, o_vld}, 32'd0);

        repeat (150) begin
            logic ld;
            int   dly;
            ld  = 1'($urandom);
            dly = (($urandom & 7) == 0) ? $urandom_range(TMO + 1, TMO + 3) : $urandom_range(0, TMO);
            run_instr(ld, 3'($urandom), $urandom, $urandom, 5'($urandom), 1'($urandom),
                      $urandom, dly, $urandom);
            if ($urandom_range(0, 3) == 0) begin
                i_dmem_rvld = 1'($urandom);
                tick();
                i_dmem_rvld = 0;
                chk("gap_vld", {31'd0, o_vld}, 32'd0);
            end
        end

        // Reset two cycles into WAIT drops the load; later response is ignored.
        i_vld = 1; i_mem_reg = 1; i_funct3 = 3'b010; i_rd_waddr = 5'd3; i_rd_wen = 1;
        tick();
        idle_inputs();
        tick();
        i_rst = 1;
        tick();
        i_rst = 0;
        err_m = 1'b0;
        chk("rstw_vld", {31'd0, o_vld}, 32'd0);
        chk("rstw_err", {31'd0, o_err}, 32'd0);
        chk("rstw_rdy", {31'd0, o_rdy}, 32'd1);
        i_dmem_rvld = 1; i_dmem_rdata = 32'hFFFF_FFFF;
        tick();
        i_dmem_rvld = 0;
        chk("rstw_late_vld", {31'd0, o_vld}, 32'd0);
        chk("rstw_late_rdy", {31'd0, o_rdy}, 32'd1);

        // Timeout after TMO WAIT cycles, then sticky error and ignored late response.
        run_instr(1, 3'b000, 32'h0, 0, 5'd4, 1, 0, TMO + 5, 32'hC1);
        chk("tmo_err", {31'd0, o_err}, 32'd1);
        i_dmem_rvld = 1;
        tick();
        i_dmem_rvld = 0;
        chk("tmo_late_vld", {31'd0, o_vld}, 32'd0);
        chk("tmo_err_held", {31'd0, o_err}, 32'd1);
        chk("tmo_rdy", {31'd0, o_rdy}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
